// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: round-robin arbiter granting one 4-way resource with bounded hold and a dead cycle between grants
module rr_grant_sequencer #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       expired
);
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, idx_n, winner;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             exp_n, drop, hit;

    // first requester at or after ptr, scanning upward with 2-bit wrap
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end

    assign drop = !req[grant_idx];
    assign hit  = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

    // arbitration in IDLE, release by drop or hold expiry in BUSY
    always_comb begin
        state_n = state;
        idx_n   = grant_idx;
        ptr_n   = ptr;
        cnt_n   = cnt;
        exp_n   = 1'b0;
        if (state == IDLE) begin
            if (enable && req != 4'b0) begin
                state_n = BUSY;
                idx_n   = winner;
                cnt_n   = CNT_W'(1);
            end
        end else if (drop || hit) begin
            state_n = IDLE;
            ptr_n   = grant_idx + 2'd1;
            exp_n   = hit && !drop;
        end else begin
            cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        end
    end

    // all outputs come straight from flops; grant_valid is the BUSY state bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= 2'd0;
            ptr       <= 2'd0;
            cnt       <= '0;
            expired   <= 1'b0;
        end else begin
            state     <= state_n;
            grant_idx <= idx_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            expired   <= exp_n;
        end
    end

    assign grant_valid = (state == BUSY);
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb_rr_grant_sequencer: directed stimulus with a grant-episode scoreboard and per-cycle invariant monitor
module tb_rr_grant_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       expired;

    rr_grant_sequencer #(.MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .req(req),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input int idx, input int len, input int exp);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // request vector as seen by the DUT at each rising edge
    logic [3:0] req_q;
    always @(posedge clk) req_q <= req;

    logic [3:0] dec, prev_dec;
    logic       prev_exp;
    logic       in_ep;
    int         ep_idx, ep_len;
    exp_t       e;

    // monitor: decoded one-hot invariants every cycle, grant episodes checked against the scoreboard
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            in_ep    = 1'b0;
            prev_dec = 4'b0;
            prev_exp = 1'b0;
        end else begin
            dec = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
            if (grant_valid) chk("req_held", int'(req_q[grant_idx]), 1);
            if (dec != 4'b0 && prev_dec != 4'b0) chk("dead_cycle", int'(dec), int'(prev_dec));
            if (expired) begin
                chk("exp_while_valid", int'(grant_valid), 0);
                chk("exp_width", int'(prev_exp), 0);
            end
            if (grant_valid && !in_ep) begin
                in_ep  = 1'b1;
                ep_idx = int'(grant_idx);
                ep_len = 1;
            end else if (grant_valid) begin
                ep_len++;
            end else if (in_ep) begin
                in_ep = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_grant", ep_idx, -1);
                end else begin
                    e = sb.pop_front();
                    chk("grant_idx", ep_idx, e.idx);
                    chk("grant_len", ep_len, e.len);
                    chk("expired", int'(expired), e.exp);
                end
            end
            prev_dec = dec;
            prev_exp = expired;
        end
    end

    initial begin
        // reset held with all requesters active
        rst    = 1'b1;
        enable = 1'b1;
        req    = 4'b1111;
        cyc(3);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_expired", int'(expired), 0);
        // rotation 0,1,2,3,0 each 4 cycles with expiry
        for (int i = 0; i < 5; i++) push(i % 4, 4, 1);
        rst = 1'b0;
        cyc(25);
        // early release of idx 2 after 2 cycles, then wrap from ptr 3 to idx 0
        req = 4'b0100;
        push(2, 2, 0);
        cyc(2);
        req = 4'b0000;
        cyc(1);
        req = 4'b0101;
        push(0, 3, 0);
        cyc(3);
        req = 4'b0000;
        cyc(1);
        // move ptr to 3, then skip/wrap to idx 1, then idx 3 until expiry
        req = 4'b0100;
        push(2, 1, 0);
        cyc(1);
        req = 4'b0000;
        cyc(1);
        req = 4'b0010;
        push(1, 2, 0);
        cyc(2);
        req = 4'b0000;
        cyc(1);
        req = 4'b1000;
        push(3, 4, 1);
        cyc(5);
        // enable gating: nothing for 10 cycles, then grant; disabling mid-grant keeps it
        req    = 4'b0001;
        enable = 1'b0;
        cyc(10);
        chk("enable_gate", int'(grant_valid), 0);
        enable = 1'b1;
        push(0, 3, 0);
        cyc(1);
        enable = 1'b0;
        cyc(2);
        req = 4'b0000;
        cyc(1);
        enable = 1'b1;
        // async reset mid-grant of idx 1; afterwards ptr is 0 so idx 0 wins
        req = 4'b0010;
        cyc(2);
        chk("pre_rst_valid", int'(grant_valid), 1);
        rst = 1'b1;
        req = 4'b0011;
        #1;
        chk("async_rst_valid", int'(grant_valid), 0);
        chk("async_rst_idx", int'(grant_idx), 0);
        chk("async_rst_expired", int'(expired), 0);
        #1;
        rst = 1'b0;
        push(0, 2, 0);
        cyc(2);
        req = 4'b0000;
        cyc(3);
        chk("sb_empty", sb.size(), 0);
        chk("episode_open", int'(in_ep), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        if (n_err != 0) $fatal(1, "errors detected");
        $finish;
    end
endmodule
